// File: rtl/acc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | acc_pkg : shared types and constants for the accumulator front-end |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package acc_pkg;

    typedef enum logic [1:0] {
        REL       = 2'b00,
        PRESS_CHK = 2'b01,
        HELD      = 2'b10,
        REL_CHK   = 2'b11
    } kh_state_t;

    localparam int DEFAULT_DEBOUNCE = 50000;

endpackage
`default_nettype wire

// File: rtl/key_handshake_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync2 : two-flop synchronizer with programmable reset level        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/key_handshake.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_handshake : debounced key -> subiu/desceu toggle pair + pulses |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module key_handshake
    import acc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic subiu,
    output logic desceu,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RAW_RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             key_sync;
    logic             key_s;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_done;

    kh_state_t        state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             subiu_d, subiu_q;
    logic             desceu_d, desceu_q;
    logic             pressed_d, pressed_q;
    logic             subiu_dly_d, subiu_dly_q;
    logic             desceu_dly_d, desceu_dly_q;
    logic             press_pulse_d, press_pulse_q;
    logic             release_pulse_d, release_pulse_q;

    sync2 #(
        .RST_VAL (RAW_RELEASED)
    ) u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_raw),
        .q     (key_sync)
    );

    assign key_s = KEY_ACTIVE_LOW ? ~key_sync : key_sync;

    // The CHK entry cycle already counts as one stable sample, so acceptance
    // fires once this cycle's increment reaches DEBOUNCE_CYCLES-1.
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign cnt_done = (cnt_inc >= CNT_LAST);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        subiu_d         = subiu_q;
        desceu_d        = desceu_q;
        pressed_d       = pressed_q;
        subiu_dly_d     = subiu_q;
        desceu_dly_d    = desceu_q;
        press_pulse_d   = subiu_q ^ subiu_dly_q;
        release_pulse_d = desceu_q ^ desceu_dly_q;

        case (state_q)
            REL: begin
                if (key_s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    subiu_d   = ~subiu_q;
                    pressed_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (key_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d   = REL;
                    cnt_d     = '0;
                    desceu_d  = ~desceu_q;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= REL;
            cnt_q           <= '0;
            subiu_q         <= 1'b0;
            desceu_q        <= 1'b0;
            pressed_q       <= 1'b0;
            subiu_dly_q     <= 1'b0;
            desceu_dly_q    <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            subiu_q         <= subiu_d;
            desceu_q        <= desceu_d;
            pressed_q       <= pressed_d;
            subiu_dly_q     <= subiu_dly_d;
            desceu_dly_q    <= desceu_dly_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    assign subiu         = subiu_q;
    assign desceu        = desceu_q;
    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_key_handshake.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_key_handshake : directed + random bench with run-length model   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_key_handshake;

    localparam int N = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic key_raw = 1'b1;
    logic subiu, desceu, pressed, press_pulse, release_pulse;

    int checks = 0;
    int errors = 0;

    key_handshake #(
        .DEBOUNCE_CYCLES (N),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_raw       (key_raw),
        .subiu         (subiu),
        .desceu        (desceu),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    // Reference: raw pin delayed two samples; a level differing from the
    // accepted one for N consecutive samples is accepted on the Nth sample.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    logic m_subiu = 1'b0, m_desceu = 1'b0, m_pressed = 1'b0;
    logic m_pp = 1'b0, m_rp = 1'b0, m_pevt = 1'b0, m_revt = 1'b0;
    int   m_run = 0;

    always @(posedge clk or negedge rst_n) begin
        logic ks;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_subiu = 1'b0; m_desceu = 1'b0; m_pressed = 1'b0;
            m_pp = 1'b0; m_rp = 1'b0; m_pevt = 1'b0; m_revt = 1'b0;
            m_run = 0;
        end else begin
            m_pp = m_pevt;
            m_rp = m_revt;
            m_pevt = 1'b0;
            m_revt = 1'b0;
            ks = !m_s2;
            m_s2 = m_s1;
            m_s1 = key_raw;
            if (ks != m_pressed) m_run = m_run + 1;
            else                 m_run = 0;
            if (m_run == N) begin
                m_run = 0;
                m_pressed = ks;
                if (ks) begin m_subiu  = !m_subiu;  m_pevt = 1'b1; end
                else    begin m_desceu = !m_desceu; m_revt = 1'b1; end
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".subiu"},   subiu,         m_subiu);
        chk({tag, ".desceu"},  desceu,        m_desceu);
        chk({tag, ".pressed"}, pressed,       m_pressed);
        chk({tag, ".ppulse"},  press_pulse,   m_pp);
        chk({tag, ".rpulse"},  release_pulse, m_rp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".subiu"},   subiu,         1'b0);
        chk({tag, ".desceu"},  desceu,        1'b0);
        chk({tag, ".pressed"}, pressed,       1'b0);
        chk({tag, ".ppulse"},  press_pulse,   1'b0);
        chk({tag, ".rpulse"},  release_pulse, 1'b0);
    endtask

    task automatic step(input string tag, input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk_model(tag);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 chk_zero({tag, ".async"});
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int   first;
        int   tog;
        int   npulse;
        logic prev;
        logic [2:0] cu;
        int   cu_hits;

        // Power-on reset
        rst_n = 1'b0; key_raw = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("por");
        rst_n = 1'b1;
        step("idle", 3);

        // Clean press: toggle on edge 6, pulse on edge 7 only
        key_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk_model("press");
            chk("press.desceu", desceu, 1'b0);
            if (e == 5) chk("press.e5.subiu", subiu, 1'b0);
            if (e == 6) begin
                chk("press.e6.subiu",   subiu,       1'b1);
                chk("press.e6.pressed", pressed,     1'b1);
                chk("press.e6.ppulse",  press_pulse, 1'b0);
            end
            if (e == 7) chk("press.e7.ppulse", press_pulse, 1'b1);
            if (e == 8) chk("press.e8.ppulse", press_pulse, 1'b0);
        end

        // Async reset with key released, then 20 quiet cycles
        @(negedge clk);
        key_raw = 1'b1;
        async_reset("rst1");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_zero("rst1.hold");
        end

        // Bouncy press: 0,1,0,1 then hold 0
        key_raw = 1'b0; step("bounce", 1);
        key_raw = 1'b1; step("bounce", 1);
        key_raw = 1'b0; step("bounce", 1);
        key_raw = 1'b1; step("bounce", 1);
        key_raw = 1'b0;
        first = -1; tog = 0; prev = subiu;
        for (int e = 1; e <= 12; e++) begin
            step("bounce", 1);
            if (subiu !== prev) begin
                tog++;
                if (first < 0) first = e;
            end
            prev = subiu;
        end
        chki("bounce.edge",    first, 6);
        chki("bounce.toggles", tog,   1);

        // Full press/release against a wait-state model of opcode 111100
        @(negedge clk);
        key_raw = 1'b1;
        async_reset("rst2");
        cu = 3'b011; cu_hits = 0; npulse = 0;
        key_raw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 16) key_raw = 1'b1;
            step("full", 1);
            npulse += int'(press_pulse) + int'(release_pulse);
            if (cu == 3'b011 && subiu != desceu) begin cu = 3'b100; cu_hits++; end
            else if (cu == 3'b100 && subiu == desceu) begin cu = 3'b000; cu_hits++; end
        end
        chk("full.subiu",  subiu,  1'b1);
        chk("full.desceu", desceu, 1'b1);
        chki("full.pulses", npulse, 2);
        chki("full.cu_state", int'(cu), 0);
        chki("full.cu_steps", cu_hits, 2);

        // Short glitch: 3 cycles low is rejected
        prev = subiu; npulse = 0;
        key_raw = 1'b0;
        step("glitch", 3);
        key_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("glitch", 1);
            npulse += int'(press_pulse) + int'(release_pulse);
        end
        chk("glitch.subiu",   subiu,   prev);
        chk("glitch.pressed", pressed, 1'b0);
        chki("glitch.pulses", npulse,  0);

        // Reset two cycles into PRESS_CHK with the key held
        key_raw = 1'b0;
        step("midrst", 5);
        async_reset("midrst");
        first = -1;
        for (int e = 2; e <= 10; e++) begin
            step("midrst", 1);
            if (subiu === 1'b1 && first < 0) first = e;
        end
        chki("midrst.edge", first, 6);

        // Random key activity against the reference model
        @(negedge clk);
        key_raw = 1'b1;
        async_reset("rand");
        for (int i = 0; i < 300; i++) begin
            key_raw = 1'($urandom_range(0, 1));
            step("rand", $urandom_range(1, 2 * N));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
